// File: rtl/dist_ram_nxw.sv
// ---------------------------------------------------------------------------
// dist_ram_nxw
//
// Purpose:
//   Simple dual-address distributed RAM (one write port, one read port) of
//   2**ADDR_W words by WIDTH bits. It has a built-in clear sweep that writes
//   zero to every word, one word per clock, starting from word 0. The read
//   port is either combinational (OUT_REG=0) or registered (OUT_REG=1). The
//   registered port can return old or new data during a read-during-write
//   to the same address (WRITE_FIRST).
//
// Parameters:
//   WIDTH       data width in bits (1..64)
//   ADDR_W      address width, DEPTH = 2**ADDR_W
//   INIT        power-up contents, word n = INIT[n*WIDTH +: WIDTH]
//   OUT_REG     0 = asynchronous read, 1 = registered read
//   WRITE_FIRST registered read-during-write: 0 = old data, 1 = new data
//   CLR_ON_RST  1 = start a clear sweep automatically when reset releases
//
// Ports:
//   WCLK  in   single clock, all state changes on the rising edge
//   RST   in   synchronous active-high reset (does not touch memory contents)
//   WE    in   user write enable
//   WA    in   write address
//   D     in   write data
//   RA    in   read address, independent of WA
//   O     out  read data
//   CLR   in   single-cycle clear request
//   BUSY  out  high while a clear sweep is in progress
//   DONE  out  one-cycle pulse after the last word of a sweep is written
// ---------------------------------------------------------------------------
module dist_ram_nxw #(
  parameter int                             WIDTH       = 1,
  parameter int                             ADDR_W      = 7,
  parameter logic [WIDTH*(2**ADDR_W)-1:0]   INIT        = '0,
  parameter bit                             OUT_REG     = 1'b0,
  parameter bit                             WRITE_FIRST = 1'b0,
  parameter bit                             CLR_ON_RST  = 1'b0
) (
  input  logic              WCLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [WIDTH-1:0]  D,
  input  logic [ADDR_W-1:0] RA,
  output logic [WIDTH-1:0]  O,
  input  logic              CLR,
  output logic              BUSY,
  output logic              DONE
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              done_nxt;
  logic              start_sweep;

  // Reset seen on the previous edge; lets CLR_ON_RST detect the first edge
  // after reset releases.
  logic              rst_q = 1'b0;

  // Packed so that word n lines up with INIT[n*WIDTH +: WIDTH] directly.
  logic [DEPTH-1:0][WIDTH-1:0] mem = INIT;

  // Effective write port, shared by user writes and the clear sweep.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [WIDTH-1:0]  mem_wd;

  // A sweep is requested either by the CLR strobe or, when enabled, by the
  // first edge after reset has been released.
  assign start_sweep = CLR || (CLR_ON_RST && rst_q);

  // BUSY is simply the CLEAR state, so it rises on the edge that accepts the
  // request and falls on the edge that writes the last word.
  assign BUSY = (state == CLEAR);

  // Next-state and write-port selection. In IDLE the user owns the write
  // port unless a sweep is starting on this edge, in which case the user
  // write is dropped. In CLEAR the sweep owns the port and user writes are
  // dropped. Reset blocks every write so that memory contents survive it
  // and a sweep in flight stops at the reset edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = WA;
    mem_wd    = D;
    case (state)
      IDLE: begin
        if (start_sweep) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end else if (WE) begin
          mem_we = 1'b1;
        end
      end
      CLEAR: begin
        mem_we  = 1'b1;
        mem_wa  = cnt;
        mem_wd  = '0;
        cnt_nxt = cnt + ADDR_W'(1);
        // The edge that writes the last word ends the sweep; the counter
        // wraps naturally back to zero.
        if (&cnt) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (RST) begin
      mem_we = 1'b0;
    end
  end

  // Control registers: state, sweep counter, DONE pulse and the delayed
  // reset used to spot reset release.
  always_ff @(posedge WCLK) begin
    rst_q <= RST;
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      DONE  <= done_nxt;
    end
  end

  // Memory array write. No reset here on purpose: contents are only ever
  // changed by user writes and the clear sweep.
  always_ff @(posedge WCLK) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  generate
    if (OUT_REG) begin : g_reg_read
      logic [WIDTH-1:0] o_q;

      // Registered read. mem[RA] is the pre-edge word, which is the
      // old-data answer on a collision. With WRITE_FIRST the word being
      // written this edge (user data or sweep zero) is forwarded instead.
      always_ff @(posedge WCLK) begin
        if (RST) begin
          o_q <= '0;
        end else if (WRITE_FIRST && mem_we && (mem_wa == RA)) begin
          o_q <= mem_wd;
        end else begin
          o_q <= mem[RA];
        end
      end

      assign O = o_q;
    end else begin : g_async_read
      // Combinational read; a write shows up as soon as the edge that
      // performs it has updated the array.
      assign O = mem[RA];
    end
  endgenerate

endmodule

// File: tb/tb_dist_ram_nxw.sv
// ---------------------------------------------------------------------------
// tb_dist_ram_nxw
//
// Purpose:
//   Self-checking bench for dist_ram_nxw with WIDTH=8, ADDR_W=4 and power-up
//   word n = n+0x10. Four instances share the clock and data inputs:
//     u_async  OUT_REG=0
//     u_rf     OUT_REG=1, WRITE_FIRST=0
//     u_wf     OUT_REG=1, WRITE_FIRST=1
//     u_cor    OUT_REG=0, CLR_ON_RST=1 (own reset, held until the last test)
//   Expected values are pushed to a scoreboard queue as stimulus is applied
//   and popped when the corresponding output is sampled (1 time unit after
//   the rising edge).
// ---------------------------------------------------------------------------
module tb_dist_ram_nxw;

  localparam int W  = 8;
  localparam int AW = 4;
  localparam int N  = 16;

  function automatic logic [W*N-1:0] make_init();
    logic [W*N-1:0] r;
    r = '0;
    for (int n = 0; n < N; n++) begin
      r[n*W +: W] = W'(n + 16);
    end
    return r;
  endfunction

  localparam logic [W*N-1:0] INIT_V = make_init();

  logic          clk;
  logic          rst;
  logic          rst_c;
  logic          we;
  logic [AW-1:0] wa;
  logic [W-1:0]  d;
  logic [AW-1:0] ra;
  logic          clr;

  logic [W-1:0]  o_a, o_rf, o_wf, o_c;
  logic          busy_a, busy_rf, busy_wf, busy_c;
  logic          done_a, done_rf, done_wf, done_c;

  dist_ram_nxw #(.WIDTH(W), .ADDR_W(AW), .INIT(INIT_V), .OUT_REG(1'b0),
                 .WRITE_FIRST(1'b0), .CLR_ON_RST(1'b0)) u_async (
    .WCLK(clk), .RST(rst), .WE(we), .WA(wa), .D(d), .RA(ra), .O(o_a),
    .CLR(clr), .BUSY(busy_a), .DONE(done_a));

  dist_ram_nxw #(.WIDTH(W), .ADDR_W(AW), .INIT(INIT_V), .OUT_REG(1'b1),
                 .WRITE_FIRST(1'b0), .CLR_ON_RST(1'b0)) u_rf (
    .WCLK(clk), .RST(rst), .WE(we), .WA(wa), .D(d), .RA(ra), .O(o_rf),
    .CLR(clr), .BUSY(busy_rf), .DONE(done_rf));

  dist_ram_nxw #(.WIDTH(W), .ADDR_W(AW), .INIT(INIT_V), .OUT_REG(1'b1),
                 .WRITE_FIRST(1'b1), .CLR_ON_RST(1'b0)) u_wf (
    .WCLK(clk), .RST(rst), .WE(we), .WA(wa), .D(d), .RA(ra), .O(o_wf),
    .CLR(clr), .BUSY(busy_wf), .DONE(done_wf));

  dist_ram_nxw #(.WIDTH(W), .ADDR_W(AW), .INIT(INIT_V), .OUT_REG(1'b0),
                 .WRITE_FIRST(1'b0), .CLR_ON_RST(1'b1)) u_cor (
    .WCLK(clk), .RST(rst_c), .WE(we), .WA(wa), .D(d), .RA(ra), .O(o_c),
    .CLR(clr), .BUSY(busy_c), .DONE(done_c));

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: names and expected values in matching order.
  string        sb_name[$];
  logic [W-1:0] sb_exp[$];
  int           tests = 0;
  int           fails = 0;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  d;
    logic [AW-1:0] ra;
    logic [W-1:0]  expv;
  } vec_t;

  vec_t vecs[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we_i, input logic [AW-1:0] wa_i,
                               input logic [W-1:0] d_i, input logic [AW-1:0] ra_i,
                               input logic clr_i);
    we  = we_i;
    wa  = wa_i;
    d   = d_i;
    ra  = ra_i;
    clr = clr_i;
  endtask

  task automatic pushExp(input string name, input logic [W-1:0] v);
    sb_name.push_back(name);
    sb_exp.push_back(v);
  endtask

  task automatic checkOutput(input logic [W-1:0] act);
    string        nm;
    logic [W-1:0] ev;
    tests++;
    if (sb_exp.size() == 0) begin
      fails++;
      $display("[TB] FAIL scoreboard-empty: got %h with no expected value", act);
    end else begin
      nm = sb_name.pop_front();
      ev = sb_exp.pop_front();
      if (act !== ev) begin
        fails++;
        $display("[TB] FAIL %s: got %h expected %h", nm, act, ev);
      end
    end
  endtask

  // Hard stop in case something never returns.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   busy_cnt;
    int   done_cnt;
    int   cyc;
    logic prev_busy;
    logic done_fall;
    vec_t v;

    // Table for the asynchronous read port: every word after power-up,
    // then writes checked on the edge that performs them.
    for (int i = 0; i < N; i++) begin
      vecs[i] = {1'b0, 4'd0, 8'h00, 4'(i), 8'(16 + i)};
    end
    vecs[16] = {1'b1, 4'd5, 8'hA5, 4'd5, 8'hA5};
    vecs[17] = {1'b1, 4'd4, 8'h44, 4'd5, 8'hA5};
    vecs[18] = {1'b0, 4'd0, 8'h00, 4'd4, 8'h44};
    vecs[19] = {1'b0, 4'd0, 8'h00, 4'd6, 8'h16};

    rst   = 1'b1;
    rst_c = 1'b1;
    applyStimulus(1'b0, 4'd0, 8'h00, 4'd0, 1'b0);
    repeat (2) tick();

    // Reset state, with CLR and WE asserted to prove they are ignored.
    applyStimulus(1'b1, 4'd7, 8'hFF, 4'd7, 1'b1);
    tick();
    pushExp("rst busy_a", 8'h00);      checkOutput(8'(busy_a));
    pushExp("rst done_a", 8'h00);      checkOutput(8'(done_a));
    pushExp("rst o_rf", 8'h00);        checkOutput(o_rf);
    pushExp("rst o_wf", 8'h00);        checkOutput(o_wf);
    pushExp("rst busy_rf", 8'h00);     checkOutput(8'(busy_rf));
    pushExp("rst done_rf", 8'h00);     checkOutput(8'(done_rf));
    pushExp("rst busy_wf", 8'h00);     checkOutput(8'(busy_wf));
    pushExp("rst done_wf", 8'h00);     checkOutput(8'(done_wf));
    pushExp("rst busy_c", 8'h00);      checkOutput(8'(busy_c));
    pushExp("rst no write", 8'h17);    checkOutput(o_a);

    applyStimulus(1'b0, 4'd0, 8'h00, 4'd0, 1'b0);
    rst = 1'b0;
    tick();
    pushExp("idle after rst busy", 8'h00); checkOutput(8'(busy_a));

    // Table-driven asynchronous reads and writes.
    for (int i = 0; i < 20; i++) begin
      v = vecs[i];
      applyStimulus(v.we, v.wa, v.d, v.ra, 1'b0);
      pushExp($sformatf("async vec%0d ra=%0d", i, v.ra), v.expv);
      tick();
      checkOutput(o_a);
    end

    // Combinational read shows old data before the edge, new after it.
    applyStimulus(1'b1, 4'd5, 8'h5A, 4'd5, 1'b0);
    #1;
    pushExp("async pre-edge", 8'hA5);  checkOutput(o_a);
    tick();
    pushExp("async post-edge", 8'h5A); checkOutput(o_a);

    // Registered read-during-write on the same address.
    applyStimulus(1'b1, 4'd3, 8'h77, 4'd3, 1'b0);
    tick();
    pushExp("rf collide old", 8'h13);  checkOutput(o_rf);
    pushExp("wf collide new", 8'h77);  checkOutput(o_wf);
    applyStimulus(1'b0, 4'd0, 8'h00, 4'd3, 1'b0);
    tick();
    pushExp("rf next edge", 8'h77);    checkOutput(o_rf);
    pushExp("wf next edge", 8'h77);    checkOutput(o_wf);
    applyStimulus(1'b1, 4'd2, 8'h22, 4'd3, 1'b0);
    tick();
    pushExp("wf other addr", 8'h77);   checkOutput(o_wf);

    // Sweep aborted by reset after six words.
    applyStimulus(1'b0, 4'd0, 8'h00, 4'd10, 1'b1);
    tick();
    pushExp("sweep start busy", 8'h01); checkOutput(8'(busy_a));
    applyStimulus(1'b0, 4'd0, 8'h00, 4'd10, 1'b0);
    repeat (6) tick();
    pushExp("mid sweep busy", 8'h01);  checkOutput(8'(busy_a));
    rst = 1'b1;
    tick();
    pushExp("abort busy", 8'h00);      checkOutput(8'(busy_a));
    pushExp("abort done", 8'h00);      checkOutput(8'(done_a));
    pushExp("abort o_rf", 8'h00);      checkOutput(o_rf);
    rst = 1'b0;
    tick();
    pushExp("no auto sweep", 8'h00);   checkOutput(8'(busy_a));
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, 4'd0, 8'h00, 4'(i), 1'b0);
      pushExp($sformatf("abort word%0d", i), (i < 6) ? 8'h00 : 8'(16 + i));
      tick();
      checkOutput(o_a);
    end

    // Full clear sweep: length, DONE alignment, partial contents mid-sweep.
    applyStimulus(1'b0, 4'd0, 8'h00, 4'd8, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 8'h00, 4'd8, 1'b0);
    busy_cnt  = 0;
    done_cnt  = 0;
    done_fall = 1'b0;
    prev_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (busy_a) busy_cnt++;
      if (done_a) begin
        done_cnt++;
        if (prev_busy && !busy_a) done_fall = 1'b1;
      end
      prev_busy = busy_a;
      if (c == 8) begin
        pushExp("partial before word8", 8'h18); checkOutput(o_a);
      end
      if (c == 9) begin
        pushExp("partial after word8", 8'h00);  checkOutput(o_a);
        pushExp("sweep rf old", 8'h18);         checkOutput(o_rf);
        pushExp("sweep wf new", 8'h00);         checkOutput(o_wf);
      end
      tick();
    end
    pushExp("clr busy cycles", 8'd16); checkOutput(8'(busy_cnt));
    pushExp("clr done pulses", 8'd1);  checkOutput(8'(done_cnt));
    pushExp("done at busy fall", 8'h01); checkOutput(8'(done_fall));
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, 4'd0, 8'h00, 4'(i), 1'b0);
      pushExp($sformatf("cleared word%0d", i), 8'h00);
      tick();
      checkOutput(o_a);
    end

    // Sweep with user writes held on and CLR re-pulsed mid-sweep; the write
    // on the accepting edge must be dropped as well.
    applyStimulus(1'b1, 4'd12, 8'hEE, 4'd12, 1'b1);
    tick();
    pushExp("start drops write", 8'h00); checkOutput(o_a);
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy_a) begin
        busy_cnt++;
        applyStimulus(1'b1, 4'd2, 8'hEE, 4'd2, (c == 5));
      end else begin
        applyStimulus(1'b0, 4'd0, 8'h00, 4'd2, 1'b0);
      end
      tick();
    end
    pushExp("restart ignored cycles", 8'd16); checkOutput(8'(busy_cnt));
    pushExp("write dropped word2", 8'h00);    checkOutput(o_a);

    // Automatic sweep after reset release.
    applyStimulus(1'b0, 4'd0, 8'h00, 4'd15, 1'b0);
    rst_c = 1'b0;
    tick();
    pushExp("cor busy after release", 8'h01); checkOutput(8'(busy_c));
    cyc = 0;
    while (!done_c && cyc < 40) begin
      tick();
      cyc++;
    end
    pushExp("cor done latency", 8'd16);  checkOutput(8'(cyc));
    pushExp("cor busy at done", 8'h00);  checkOutput(8'(busy_c));
    tick();
    pushExp("cor done one cycle", 8'h00); checkOutput(8'(done_c));
    pushExp("cor no restart", 8'h00);     checkOutput(8'(busy_c));
    pushExp("cor word15 cleared", 8'h00); checkOutput(o_c);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
